// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch target buffer.
// Provides the default entry layout, counter reset/allocate constants and
// the saturating counter update used on branch resolution.
//
// Contents:
//   DEF_*              default geometry (16 entries, 2-bit counters)
//   btb_entry_t        {valid, tag, target, ctr} at the default widths
//   CTR_WEAK_TAKEN(w)  1 followed by w-1 zeros
//   CTR_WEAK_NT(w)     0 followed by w-1 ones (0 when w == 1)
//   sat_update(c,t,w)  +1 on taken / -1 on not taken, clamped to [0, 2^w-1]
package bpred_pkg;

   localparam int DEF_ENTRIES = 16;
   localparam int DEF_IDX_W   = 4;
   localparam int DEF_TAG_W   = 30 - DEF_IDX_W;
   localparam int DEF_CTR_W   = 2;

   typedef struct packed {
      logic                 valid;
      logic [DEF_TAG_W-1:0] tag;
      logic [31:0]          target;
      logic [DEF_CTR_W-1:0] ctr;
   } btb_entry_t;

   // Counter helpers work on a 32-bit container; callers cast to their width.
   function automatic logic [31:0] CTR_WEAK_TAKEN(input int w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic logic [31:0] CTR_WEAK_NT(input int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                              input logic        taken,
                                              input int          w);
      logic [31:0] max_val;
      max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      if (taken)
         return (ctr == max_val) ? ctr : ctr + 32'd1;
      else
         return (ctr == 32'd0) ? ctr : ctr - 32'd1;
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup / update / statistics bundle between the pipeline and the BTB.
// Zero-latency lookup, registered update; no backpressure (every update is taken).
//
// Modports:
//   master  pipeline side: drives lk_pc, upd_*, flush_all; reads predictions
//   slave   predictor side: the branch_predictor module
interface branch_predictor_if;

   logic [31:0] lk_pc;
   logic        lk_taken;
   logic [31:0] lk_target;

   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;

   logic        mispredict;
   logic        flush_all;

   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   modport master (
      output lk_pc,
      input  lk_taken, lk_target,
      output upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
      input  mispredict,
      output flush_all,
      input  stat_branches, stat_mispredicts
   );

   modport slave (
      input  lk_pc,
      output lk_taken, lk_target,
      input  upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
      output mispredict,
      input  flush_all,
      output stat_branches, stat_mispredicts
   );

endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters (IF lookup, EX update).
// Lookup and mispredict are combinational; table updates land on the next CLK edge.
// No backpressure: every upd_en is consumed the cycle it is presented (flush_all drops it).
//
// Ports:
//   CLK, nRST   clock, asynchronous active-low reset
//   bp (slave)  lk_pc -> lk_taken/lk_target; upd_* from EX; mispredict;
//               flush_all; stat_branches/stat_mispredicts
// Optional: define BRANCH_PREDICTOR_STATS_EN for saturating resolved-branch and
// misprediction counters; otherwise both stat outputs are tied to zero.
module branch_predictor
   import bpred_pkg::*;
#(
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int CTR_W   = DEF_CTR_W
)(
   input  logic               CLK,
   input  logic               nRST,
   branch_predictor_if.slave  bp
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   // Same field order as btb_entry_t, sized by this instance's parameters.
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      logic [CTR_W-1:0] ctr;
   } entry_t;

   entry_t tbl [ENTRIES];

   // ------------------------------------------------------------------
   // Lookup (IF)
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic             lk_taken_c;

   assign lk_idx     = bp.lk_pc[IDX_W+1:2];
   assign lk_tag     = bp.lk_pc[31:IDX_W+2];
   assign lk_hit     = tbl[lk_idx].valid && (tbl[lk_idx].tag == lk_tag);
   assign lk_taken_c = lk_hit && tbl[lk_idx].ctr[CTR_W-1];

   assign bp.lk_taken  = lk_taken_c;
   assign bp.lk_target = lk_taken_c ? tbl[lk_idx].target : 32'd0;

   // ------------------------------------------------------------------
   // Misprediction: a wrong direction, or a taken branch whose carried
   // target disagrees with the resolved one. Table state is not consulted.
   // ------------------------------------------------------------------
   logic mispredict_c;

   assign mispredict_c = bp.upd_en &&
                         ((bp.upd_pred_taken != bp.upd_taken) ||
                          (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
   assign bp.mispredict = mispredict_c;

   // ------------------------------------------------------------------
   // Update (EX)
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;

   assign upd_idx = bp.upd_pc[IDX_W+1:2];
   assign upd_tag = bp.upd_pc[31:IDX_W+2];
   assign upd_hit = tbl[upd_idx].valid && (tbl[upd_idx].tag == upd_tag);

   // Word-aligned PCs: the byte offset never participates in indexing.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{bp.lk_pc[1:0], bp.upd_pc[1:0]};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i].valid  <= 1'b0;
            tbl[i].tag    <= '0;
            tbl[i].target <= 32'd0;
            tbl[i].ctr    <= CTR_W'(CTR_WEAK_NT(CTR_W));
         end
      end else if (bp.flush_all) begin
         // Only validity is dropped; counters and targets are left as-is.
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i].valid <= 1'b0;
         end
      end else if (bp.upd_en) begin
         if (upd_hit) begin
            tbl[upd_idx].ctr <= CTR_W'(sat_update(32'(tbl[upd_idx].ctr), bp.upd_taken, CTR_W));
            if (bp.upd_taken) begin
               tbl[upd_idx].target <= bp.upd_target;
            end
         end else if (bp.upd_taken) begin
            // Allocate on a taken miss, evicting whatever aliased here.
            // Not-taken misses never displace an existing entry.
            tbl[upd_idx] <= '{valid:  1'b1,
                              tag:    upd_tag,
                              target: bp.upd_target,
                              ctr:    CTR_W'(CTR_WEAK_TAKEN(CTR_W))};
         end
      end
   end

   // ------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------
`ifdef BRANCH_PREDICTOR_STATS_EN
   logic [31:0] stat_br_q;
   logic [31:0] stat_mp_q;

   // Counted on upd_en alone, so an update dropped by flush_all still counts.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_br_q <= 32'd0;
         stat_mp_q <= 32'd0;
      end else begin
         if (bp.upd_en && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_q <= stat_br_q + 32'd1;
         end
         if (mispredict_c && (stat_mp_q != 32'hFFFF_FFFF)) begin
            stat_mp_q <= stat_mp_q + 32'd1;
         end
      end
   end

   assign bp.stat_branches    = stat_br_q;
   assign bp.stat_mispredicts = stat_mp_q;
`else
   assign bp.stat_branches    = 32'd0;
   assign bp.stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, CTR_W=2).
// Stimulus is applied on the falling edge; registered effects are checked #1 after the rising edge.
// Stat counters are checked against a running model when BRANCH_PREDICTOR_STATS_EN is defined, else against 0.
module tb_branch_predictor;

   logic CLK;
   logic nRST;

   branch_predictor_if bp_if ();

   branch_predictor #(.ENTRIES(16), .CTR_W(2)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bp   (bp_if)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int exp_br = 0;
   int exp_mp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_stats(input string tag);
`ifdef BRANCH_PREDICTOR_STATS_EN
      chk({tag, "_stat_br"}, bp_if.stat_branches,    32'(exp_br));
      chk({tag, "_stat_mp"}, bp_if.stat_mispredicts, 32'(exp_mp));
`else
      chk({tag, "_stat_br"}, bp_if.stat_branches,    32'd0);
      chk({tag, "_stat_mp"}, bp_if.stat_mispredicts, 32'd0);
`endif
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc,
                         input logic exp_t, input logic [31:0] exp_tgt);
      bp_if.lk_pc = pc;
      #1;
      chk({tag, "_taken"},  32'(bp_if.lk_taken), 32'(exp_t));
      chk({tag, "_target"}, bp_if.lk_target,     exp_tgt);
   endtask

   // One resolved branch: mispredict checked before the edge, stats after it.
   task automatic do_upd(input string tag, input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                         input logic exp_mis, input logic fl);
      @(negedge CLK);
      bp_if.upd_en          = 1'b1;
      bp_if.upd_pc          = pc;
      bp_if.upd_taken       = t;
      bp_if.upd_target      = tgt;
      bp_if.upd_pred_taken  = pt;
      bp_if.upd_pred_target = ptgt;
      bp_if.flush_all       = fl;
      #1;
      chk({tag, "_mispredict"}, 32'(bp_if.mispredict), 32'(exp_mis));
      exp_br++;
      if (exp_mis) exp_mp++;
      @(posedge CLK);
      #1;
      bp_if.upd_en    = 1'b0;
      bp_if.flush_all = 1'b0;
      chk_stats(tag);
   endtask

   initial begin
      nRST                  = 1'b0;
      bp_if.lk_pc           = 32'h0000_0040;
      bp_if.upd_en          = 1'b0;
      bp_if.upd_pc          = 32'd0;
      bp_if.upd_taken       = 1'b0;
      bp_if.upd_target      = 32'd0;
      bp_if.upd_pred_taken  = 1'b0;
      bp_if.upd_pred_target = 32'd0;
      bp_if.flush_all       = 1'b0;

      // Reset state
      #12;
      lookup("rst_lk40", 32'h40, 1'b0, 32'd0);
      chk("rst_mispredict", 32'(bp_if.mispredict), 32'd0);
      chk_stats("rst");
      @(negedge CLK);
      nRST = 1'b1;

      // First allocation; same-cycle lookup must still see the old (empty) entry.
      @(negedge CLK);
      bp_if.lk_pc           = 32'h40;
      bp_if.upd_en          = 1'b1;
      bp_if.upd_pc          = 32'h40;
      bp_if.upd_taken       = 1'b1;
      bp_if.upd_target      = 32'h100;
      bp_if.upd_pred_taken  = 1'b0;
      bp_if.upd_pred_target = 32'd0;
      #1;
      chk("alloc_mispredict", 32'(bp_if.mispredict), 32'd1);
      chk("alloc_nobypass",   32'(bp_if.lk_taken),   32'd0);
      exp_br++;
      exp_mp++;
      @(posedge CLK);
      #1;
      bp_if.upd_en = 1'b0;
      chk_stats("alloc");
      lookup("alloc_lk40", 32'h40, 1'b1, 32'h100);             // ctr 10

      // Decrement to the floor and hold there
      do_upd("nt1", 32'h40, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1, 1'b0);   // 10 -> 01
      lookup("nt1_lk40", 32'h40, 1'b0, 32'd0);
      do_upd("nt2", 32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);     // 01 -> 00
      do_upd("nt3", 32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);     // 00 -> 00
      do_upd("t_up1", 32'h40, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 1'b0); // 00 -> 01
      lookup("t_up1_lk40", 32'h40, 1'b0, 32'd0);
      do_upd("t_up2", 32'h40, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 1'b0); // 01 -> 10
      lookup("t_up2_lk40", 32'h40, 1'b1, 32'h100);

      // Increment to the ceiling and hold there
      do_upd("t_sat1", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0); // 10 -> 11
      do_upd("t_sat2", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0); // 11 -> 11
      do_upd("dn1", 32'h40, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1, 1'b0);     // 11 -> 10
      lookup("dn1_lk40", 32'h40, 1'b1, 32'h100);
      do_upd("dn2", 32'h40, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1, 1'b0);     // 10 -> 01
      lookup("dn2_lk40", 32'h40, 1'b0, 32'd0);

      // Taken hit rewrites the target
      do_upd("retgt", 32'h40, 1'b1, 32'h140, 1'b0, 32'd0, 1'b1, 1'b0);   // 01 -> 10
      lookup("retgt_lk40", 32'h40, 1'b1, 32'h140);

      // Aliasing at index 0: 0x80 displaces 0x40 only when taken
      do_upd("alias_nt", 32'h80, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      lookup("alias_nt_lk40", 32'h40, 1'b1, 32'h140);
      lookup("alias_nt_lk80", 32'h80, 1'b0, 32'd0);
      do_upd("alias_t", 32'h80, 1'b1, 32'h200, 1'b0, 32'd0, 1'b1, 1'b0);
      lookup("alias_t_lk40", 32'h40, 1'b0, 32'd0);
      lookup("alias_t_lk80", 32'h80, 1'b1, 32'h200);

      // Right direction, wrong target
      do_upd("tgt_miss", 32'h80, 1'b1, 32'h104, 1'b1, 32'h100, 1'b1, 1'b0);
      lookup("tgt_miss_lk80", 32'h80, 1'b1, 32'h104);
      do_upd("tgt_ok", 32'h80, 1'b1, 32'h104, 1'b1, 32'h104, 1'b0, 1'b0);

      // No update presented: mismatched carried fields are ignored
      @(negedge CLK);
      bp_if.upd_en          = 1'b0;
      bp_if.upd_taken       = 1'b1;
      bp_if.upd_pred_taken  = 1'b0;
      bp_if.upd_pred_target = 32'h999;
      #1;
      chk("idle_mispredict", 32'(bp_if.mispredict), 32'd0);

      // flush_all wins over a same-cycle update, which still reports mispredict
      do_upd("flush", 32'h44, 1'b1, 32'h300, 1'b0, 32'd0, 1'b1, 1'b1);
      lookup("flush_lk80", 32'h80, 1'b0, 32'd0);
      lookup("flush_lk44", 32'h44, 1'b0, 32'd0);
      lookup("flush_lk40", 32'h40, 1'b0, 32'd0);

      // Re-allocation after flush starts at weakly taken, not the stale counter
      do_upd("realloc", 32'h80, 1'b1, 32'h204, 1'b0, 32'd0, 1'b1, 1'b0);
      lookup("realloc_lk80", 32'h80, 1'b1, 32'h204);
      do_upd("realloc_nt", 32'h80, 1'b0, 32'd0, 1'b1, 32'h204, 1'b1, 1'b0);
      lookup("realloc_nt_lk80", 32'h80, 1'b0, 32'd0);
      do_upd("realloc_t", 32'h80, 1'b1, 32'h204, 1'b0, 32'd0, 1'b1, 1'b0);
      lookup("realloc_t_lk80", 32'h80, 1'b1, 32'h204);

      // Reset asserted while an update is presented
      @(negedge CLK);
      bp_if.upd_en          = 1'b1;
      bp_if.upd_pc          = 32'h48;
      bp_if.upd_taken       = 1'b1;
      bp_if.upd_target      = 32'h400;
      bp_if.upd_pred_taken  = 1'b0;
      bp_if.upd_pred_target = 32'd0;
      #1;
      nRST = 1'b0;
      #1;
      lookup("arst_lk80", 32'h80, 1'b0, 32'd0);
      chk("arst_mispredict", 32'(bp_if.mispredict), 32'd1);
      @(posedge CLK);
      #1;
      bp_if.upd_en = 1'b0;
      @(negedge CLK);
      nRST   = 1'b1;
      exp_br = 0;
      exp_mp = 0;
      lookup("arst_lk48", 32'h48, 1'b0, 32'd0);
      chk_stats("arst");

      // Operation resumes after reset
      do_upd("post", 32'h48, 1'b1, 32'h400, 1'b0, 32'd0, 1'b1, 1'b0);
      lookup("post_lk48", 32'h48, 1'b1, 32'h400);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
